// File: rtl/turtle_io_pkg.sv
`default_nettype none
// ============================================================================
// Module      : turtle_io_pkg
// Description : Shared constants for the turtle I/O UART responder: register
//               offsets within the I/O window, STATUS bit positions and the
//               UART transmitter state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package turtle_io_pkg;

  // Register offsets inside the I/O window
  localparam int TX_DATA_OFS  = 0;
  localparam int STATUS_OFS   = 1;
  localparam int BAUD_DIV_OFS = 2;
  localparam int GPIO_OUT_OFS = 3;

  // STATUS register bit positions
  localparam int ST_FULL_BIT  = 0;
  localparam int ST_EMPTY_BIT = 1;
  localparam int ST_BUSY_BIT  = 2;
  localparam int ST_CNT_LSB   = 3;
  localparam int ST_CNT_MSB   = 5;
  localparam int ST_OVF_BIT   = 6;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_tx_state_e;

endpackage
`default_nettype wire

// File: rtl/turtle_sync_fifo.sv
`default_nettype none
// ============================================================================
// Module      : turtle_sync_fifo
// Description : Single-clock FIFO with an explicit occupancy counter and a
//               combinational head output (first-word fall-through).
// Ports       : clk, reset_n     - clock, async active-low reset
//               push_i, wdata_i  - write request and data
//               pop_i            - remove head (ignored when empty)
//               rdata_o          - current head entry
//               full_o, empty_o  - occupancy flags
//               count_o          - number of stored entries (0..DEPTH)
// Revision    : 1.0 - initial release
// ============================================================================
module turtle_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [CNT_W-1:0] count_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push;
  logic             do_pop;

  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign rdata_o = mem_q[rd_ptr_q];

  assign do_pop  = pop_i && !empty_o;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign do_push = push_i && (!full_o || do_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    // Power-of-two depth lets the pointers wrap naturally.
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: entries are only read after being written.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule
`default_nettype wire

// File: rtl/turtle_io_uart_responder.sv
`default_nettype none
// ============================================================================
// Module      : turtle_io_uart_responder
// Description : External I/O bus responder. Decodes an aligned I/O window,
//               steers int_mem_select and serves TX_DATA, STATUS, BAUD_DIV and
//               GPIO_OUT registers. Transmits queued bytes as 8N1 frames.
// Ports       : clk, reset_n            - clock, async active-low reset
//               data_addr, write_enable,
//               write_data              - bus request from the core
//               read_data               - combinational read data
//               int_mem_select          - 0 when the address is in the window
//               uart_tx                 - serial output, idle high
//               gpio_out                - GPIO output register
// Revision    : 1.0 - initial release
// ============================================================================
module turtle_io_uart_responder
  import turtle_io_pkg::*;
#(
  parameter int                  DATA_W           = 8,
  parameter int                  D_ADDR_W         = 12,
  parameter logic [D_ADDR_W-1:0] IO_BASE          = 12'hF00,
  parameter int                  IO_WINDOW_W      = 4,
  parameter int                  TX_FIFO_DEPTH    = 4,
  parameter logic [DATA_W-1:0]   DEFAULT_BAUD_DIV = 8'd103
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [D_ADDR_W-1:0] data_addr,
  input  logic                write_enable,
  input  logic [DATA_W-1:0]   write_data,
  output logic [DATA_W-1:0]   read_data,
  output logic                int_mem_select,
  output logic                uart_tx,
  output logic [DATA_W-1:0]   gpio_out
);

  localparam int CNT_W = $clog2(TX_FIFO_DEPTH) + 1;

  // ---------------------------------------------------------------- decode
  logic                   hit;
  logic [IO_WINDOW_W-1:0] ofs;
  logic                   wr_en;
  logic                   push_req;

  assign hit            = (data_addr[D_ADDR_W-1:IO_WINDOW_W] == IO_BASE[D_ADDR_W-1:IO_WINDOW_W]);
  assign ofs            = data_addr[IO_WINDOW_W-1:0];
  assign int_mem_select = !hit;
  assign wr_en          = hit && write_enable;
  assign push_req       = wr_en && (ofs == IO_WINDOW_W'(TX_DATA_OFS));

  // ---------------------------------------------------------------- state
  logic [DATA_W-1:0] baud_q, baud_d;
  logic [DATA_W-1:0] gpio_q, gpio_d;
  logic              ovf_q, ovf_d;
  uart_tx_state_e    state_q, state_d;
  logic [DATA_W-1:0] cnt_q, cnt_d;
  logic [2:0]        bit_idx_q, bit_idx_d;
  logic [DATA_W-1:0] shift_q, shift_d;

  // ---------------------------------------------------------------- FIFO
  logic [DATA_W-1:0] fifo_rdata;
  logic              fifo_full;
  logic              fifo_empty;
  logic [CNT_W-1:0]  fifo_count;
  logic              pop;

  // The transmitter takes the head whenever it is idle and data is waiting.
  assign pop = (state_q == IDLE) && !fifo_empty;

  turtle_sync_fifo #(
    .WIDTH (DATA_W),
    .DEPTH (TX_FIFO_DEPTH)
  ) u_tx_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push_i  (push_req),
    .wdata_i (write_data),
    .pop_i   (pop),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  // ---------------------------------------------------------------- registers
  always_comb begin
    baud_d = baud_q;
    gpio_d = gpio_q;
    ovf_d  = ovf_q;
    if (wr_en && ofs == IO_WINDOW_W'(BAUD_DIV_OFS)) baud_d = write_data;
    if (wr_en && ofs == IO_WINDOW_W'(GPIO_OUT_OFS)) gpio_d = write_data;
    if (wr_en && ofs == IO_WINDOW_W'(STATUS_OFS) && write_data[ST_OVF_BIT]) ovf_d = 1'b0;
    // A dropped push outranks a simultaneous clear so no loss goes unreported.
    if (push_req && fifo_full && !pop) ovf_d = 1'b1;
  end

  // ---------------------------------------------------------------- TX FSM
  // Every bit holds for baud+1 clocks; the divider is sampled only on reload,
  // so a BAUD_DIV change lets the current bit finish at the old rate.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    uart_tx   = 1'b1;
    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          shift_d = fifo_rdata;
          cnt_d   = baud_q;
          state_d = START;
        end
      end
      START: begin
        uart_tx = 1'b0;
        if (cnt_q == '0) begin
          cnt_d     = baud_q;
          bit_idx_d = 3'd0;
          state_d   = DATA;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      DATA: begin
        uart_tx = shift_q[bit_idx_q];
        if (cnt_q == '0) begin
          cnt_d = baud_q;
          if (bit_idx_q == 3'd7) state_d = STOP;
          else                   bit_idx_d = bit_idx_q + 1'b1;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      STOP: begin
        if (cnt_q == '0) state_d = IDLE;
        else             cnt_d   = cnt_q - 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      baud_q    <= DEFAULT_BAUD_DIV;
      gpio_q    <= '0;
      ovf_q     <= 1'b0;
      state_q   <= IDLE;
      cnt_q     <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
    end else begin
      baud_q    <= baud_d;
      gpio_q    <= gpio_d;
      ovf_q     <= ovf_d;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
    end
  end

  assign gpio_out = gpio_q;

  // ---------------------------------------------------------------- read mux
  logic [DATA_W-1:0] status;

  always_comb begin
    status                         = '0;
    status[ST_FULL_BIT]            = fifo_full;
    status[ST_EMPTY_BIT]           = fifo_empty;
    status[ST_BUSY_BIT]            = (state_q != IDLE);
    status[ST_CNT_MSB:ST_CNT_LSB]  = 3'(fifo_count);
    status[ST_OVF_BIT]             = ovf_q;
  end

  always_comb begin
    read_data = '0;
    if (hit) begin
      case (ofs)
        IO_WINDOW_W'(STATUS_OFS):   read_data = status;
        IO_WINDOW_W'(BAUD_DIV_OFS): read_data = baud_q;
        IO_WINDOW_W'(GPIO_OUT_OFS): read_data = gpio_q;
        default:                    read_data = '0;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_turtle_io_uart_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_turtle_io_uart_responder
// Description : Self-checking bench for turtle_io_uart_responder. A serial
//               receiver decodes uart_tx into bytes with start timestamps; the
//               expected bytes, frame spacing and register contents come from
//               a small register/queue model kept here.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_turtle_io_uart_responder;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [11:0] data_addr;
  logic        write_enable;
  logic [7:0]  write_data;
  logic [7:0]  read_data;
  logic        int_mem_select;
  logic        uart_tx;
  logic [7:0]  gpio_out;

  turtle_io_uart_responder dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .data_addr      (data_addr),
    .write_enable   (write_enable),
    .write_data     (write_data),
    .read_data      (read_data),
    .int_mem_select (int_mem_select),
    .uart_tx        (uart_tx),
    .gpio_out       (gpio_out)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic bus_write(input logic [11:0] a, input logic [7:0] d);
    @(negedge clk);
    data_addr = a; write_data = d; write_enable = 1'b1;
    @(posedge clk); #1;
    write_enable = 1'b0;
  endtask

  task automatic check_read(input string nm, input logic [11:0] a, input logic [7:0] exp);
    @(negedge clk);
    data_addr = a; write_enable = 1'b0;
    #1 chk(nm, {24'd0, read_data}, {24'd0, exp});
  endtask

  // ---------------------------------------------------------- serial receiver
  int          mon_per = 104;   // clocks per bit expected by the receiver
  logic [7:0]  byte_q[$];
  int          t_q[$];
  logic        stop_q[$];

  initial begin
    int t, per, pos, target;
    logic [7:0] b;
    logic sb;
    forever begin
      @(posedge clk); #1;
      if (reset_n === 1'b1 && uart_tx === 1'b0) begin
        t = cyc; per = mon_per; pos = 0; b = '0; sb = 1'b0;
        for (int i = 1; i <= 9; i++) begin
          target = per * i + per / 2;
          while (pos < target) begin @(posedge clk); #1; pos++; end
          if (i <= 8) b[i-1] = uart_tx; else sb = uart_tx;
        end
        while (pos < 10 * per - 1) begin @(posedge clk); #1; pos++; end
        byte_q.push_back(b); t_q.push_back(t); stop_q.push_back(sb);
      end
    end
  end

  task automatic clear_rx();
    byte_q.delete(); t_q.delete(); stop_q.delete();
  endtask

  task automatic wait_frames(input int n, input int limit);
    for (int i = 0; i < limit && byte_q.size() < n; i++) @(posedge clk);
    #1 chk("frame_wait", byte_q.size() >= n, 1);
  endtask

  // Checks received frames against an expected byte list with fixed spacing.
  task automatic check_frames(input string nm, input logic [7:0] exp[$], input int per);
    chk({nm, "_count"}, byte_q.size(), exp.size());
    for (int j = 0; j < exp.size() && j < byte_q.size(); j++) begin
      chk($sformatf("%s_byte%0d", nm, j), byte_q[j], exp[j]);
      chk($sformatf("%s_stop%0d", nm, j), stop_q[j], 1);
      if (j > 0) chk($sformatf("%s_gap%0d", nm, j), t_q[j] - t_q[j-1], 10 * per + 1);
    end
  endtask

  // ---------------------------------------------------------- vector table
  typedef struct {
    logic [11:0] addr;
    logic        we;
    logic [7:0]  wd;
    logic [7:0]  rd;    // expected read before the write lands
    logic        sel;
  } vec_t;

  vec_t vt[15];

  initial begin
    vt[0]  = '{12'hF01, 1'b0, 8'h00, 8'h02, 1'b0};
    vt[1]  = '{12'hF02, 1'b0, 8'h00, 8'd103, 1'b0};
    vt[2]  = '{12'h100, 1'b0, 8'h00, 8'h00, 1'b1};
    vt[3]  = '{12'hF03, 1'b1, 8'h5A, 8'h00, 1'b0};
    vt[4]  = '{12'hF03, 1'b0, 8'h00, 8'h5A, 1'b0};
    vt[5]  = '{12'hE03, 1'b1, 8'h11, 8'h00, 1'b1};
    vt[6]  = '{12'hF03, 1'b0, 8'h00, 8'h5A, 1'b0};
    vt[7]  = '{12'hF02, 1'b1, 8'h03, 8'd103, 1'b0};
    vt[8]  = '{12'hF02, 1'b0, 8'h00, 8'h03, 1'b0};
    vt[9]  = '{12'hF00, 1'b0, 8'h00, 8'h00, 1'b0};
    vt[10] = '{12'hF07, 1'b1, 8'hFF, 8'h00, 1'b0};
    vt[11] = '{12'hF07, 1'b0, 8'h00, 8'h00, 1'b0};
    vt[12] = '{12'hF0F, 1'b0, 8'h00, 8'h00, 1'b0};
    vt[13] = '{12'hF10, 1'b0, 8'h00, 8'h00, 1'b1};
    vt[14] = '{12'hF01, 1'b0, 8'h00, 8'h02, 1'b0};
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  // ---------------------------------------------------------- main sequence
  initial begin
    logic [7:0] a5;
    logic [7:0] exp_q[$];
    logic [7:0] gpio_m, baud_m, expv, b;
    logic       e;
    int         bd, n, j, run_pos;
    int         dur[10];
    logic       lvl[10];
    logic [11:0] a;
    logic        we, hit;

    reset_n = 1'b0; data_addr = '0; write_enable = 1'b0; write_data = '0;
    #1 chk("reset_uart_tx", uart_tx, 1);
    repeat (3) @(posedge clk);
    @(negedge clk) reset_n = 1'b1;
    #1 chk("reset_gpio", gpio_out, 8'h00);

    // ---- table-driven register / decode vectors
    foreach (vt[i]) begin
      @(negedge clk);
      data_addr = vt[i].addr; write_enable = vt[i].we; write_data = vt[i].wd;
      #1;
      chk($sformatf("vec%0d_rd", i), read_data, vt[i].rd);
      chk($sformatf("vec%0d_sel", i), int_mem_select, vt[i].sel);
      @(posedge clk); #1;
      write_enable = 1'b0;
    end
    chk("gpio_after_vectors", gpio_out, 8'h5A);
    chk("uart_idle_after_vectors", uart_tx, 1);

    // ---- single frame 0xA5 at BAUD_DIV=3, cycle-exact waveform
    mon_per = 4; clear_rx();
    a5 = 8'hA5;
    bus_write(12'hF00, a5);
    data_addr = 12'hF01;
    chk("a5_pre_start", uart_tx, 1);
    for (int k = 1; k <= 41; k++) begin
      @(posedge clk); #1;
      if (k <= 40) begin
        j = (k - 1) / 4;
        e = (j == 0) ? 1'b0 : (j == 9) ? 1'b1 : a5[j-1];
        chk($sformatf("a5_wave_k%0d", k), uart_tx, e);
      end
      if (k == 40) chk("a5_busy_in_stop", read_data[2], 1);
      if (k == 41) chk("a5_busy_cleared", read_data[2], 0);
    end
    repeat (5) @(posedge clk);
    exp_q = '{8'hA5};
    check_frames("a5_rx", exp_q, 4);

    // ---- overflow: six back-to-back pushes, five frames out
    clear_rx();
    exp_q.delete();
    for (int i = 0; i < 6; i++) begin
      b = 8'($urandom);
      if (i < 5) exp_q.push_back(b);
      bus_write(12'hF00, b);
    end
    check_read("ovf_status", 12'hF01, 8'h65);
    bus_write(12'hF01, 8'h40);
    check_read("ovf_cleared", 12'hF01, 8'h25);
    wait_frames(5, 5 * 41 + 60);
    repeat (60) @(posedge clk);
    check_frames("ovf_rx", exp_q, 4);
    check_read("ovf_idle_status", 12'hF01, 8'h02);

    // ---- BAUD_DIV 3 -> 1 during data bit 3 of 0x55
    clear_rx();
    lvl = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    dur = '{4, 4, 4, 4, 4, 2, 2, 2, 2, 2};
    bus_write(12'hF00, 8'h55);
    j = 0; run_pos = 0;
    for (int k = 1; k <= 31; k++) begin
      @(posedge clk); #1;
      if (k == 17) begin data_addr = 12'hF02; write_data = 8'h01; write_enable = 1'b1; end
      if (k == 18) write_enable = 1'b0;
      if (k <= 30) begin
        chk($sformatf("baudchg_k%0d", k), uart_tx, lvl[j]);
        run_pos++;
        if (run_pos == dur[j]) begin j++; run_pos = 0; end
      end else begin
        chk("baudchg_idle", uart_tx, 1);
        chk("baudchg_readback", read_data, 8'h01);
      end
    end
    repeat (50) @(posedge clk);
    clear_rx();

    // ---- randomized register traffic against a register model
    gpio_m = 8'h5A; baud_m = 8'h01;
    for (int i = 0; i < 40; i++) begin
      hit = ($urandom_range(0, 1) == 1);
      if (hit) a = {8'hF0, 4'($urandom_range(0, 15))};
      else     a = 12'($urandom_range(0, 12'hEFF));
      we = ($urandom_range(0, 1) == 1);
      if (hit && a[3:0] == 4'd0) we = 1'b0;
      b = 8'($urandom);
      expv = 8'h00;
      if (hit) begin
        case (a[3:0])
          4'd1: expv = 8'h02;
          4'd2: expv = baud_m;
          4'd3: expv = gpio_m;
          default: expv = 8'h00;
        endcase
      end
      @(negedge clk);
      data_addr = a; write_enable = we; write_data = b;
      #1;
      chk($sformatf("rnd%0d_rd", i), read_data, expv);
      chk($sformatf("rnd%0d_sel", i), int_mem_select, !hit);
      @(posedge clk); #1;
      write_enable = 1'b0;
      if (hit && we && a[3:0] == 4'd2) baud_m = b;
      if (hit && we && a[3:0] == 4'd3) gpio_m = b;
    end
    chk("rnd_gpio_out", gpio_out, gpio_m);
    chk("rnd_uart_idle", uart_tx, 1);

    // ---- randomized transmissions at random divisors
    for (int tr = 0; tr < 6; tr++) begin
      bd = $urandom_range(0, 4);
      bus_write(12'hF02, 8'(bd));
      mon_per = bd + 1;
      clear_rx();
      exp_q.delete();
      n = $urandom_range(1, 3);
      for (int i = 0; i < n; i++) begin
        b = 8'($urandom);
        exp_q.push_back(b);
        bus_write(12'hF00, b);
      end
      wait_frames(n, n * (10 * mon_per + 1) + 30);
      repeat (5) @(posedge clk);
      check_frames($sformatf("rtx%0d", tr), exp_q, mon_per);
      check_read($sformatf("rtx%0d_status", tr), 12'hF01, 8'h02);
    end

    // ---- reset during a data bit
    bus_write(12'hF02, 8'd3);
    mon_per = 4;
    bus_write(12'hF00, 8'h00);
    bus_write(12'hF00, 8'hFF);
    repeat (8) @(posedge clk);
    #1 chk("pre_reset_tx_low", uart_tx, 0);
    #2 reset_n = 1'b0;
    #1 chk("async_reset_tx_high", uart_tx, 1);
    repeat (2) @(posedge clk);
    @(negedge clk) reset_n = 1'b1;
    check_read("post_reset_status", 12'hF01, 8'h02);
    check_read("post_reset_baud", 12'hF02, 8'd103);
    chk("post_reset_gpio", gpio_out, 8'h00);
    repeat (10) @(posedge clk);
    #1 chk("post_reset_tx_idle", uart_tx, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
